// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: field widths, opcode encodings and the CDB bundle.
package tomasulo_pkg;

    localparam int DATA_W = 16;
    localparam int ROB_W  = 3;
    localparam int RS_W   = 2;
    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_MUL   = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_LOAD  = 4'b0100,
        OP_STORE = 4'b0101,
        OP_BEQ   = 4'b0110,
        OP_BNE   = 4'b0111
    } opcode_e;

    typedef enum logic {
        UNIT_ADD = 1'b0,
        UNIT_MUL = 1'b1
    } unit_e;

    typedef enum logic {
        MU_IDLE,
        MU_RUN
    } mu_state_e;

    typedef struct packed {
        logic              valid;
        logic              unit;
        logic [RS_W-1:0]   rsindex;
        logic [ROB_W-1:0]  rob_ind;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } cdb_t;

    function automatic logic is_mul_op(input logic [FUNC_W-1:0] f);
        return (f == OP_MUL) || (f == OP_DIV);
    endfunction

    // Upper half of the opcode space is reserved and never issues.
    function automatic logic is_add_op(input logic [FUNC_W-1:0] f);
        return !f[FUNC_W-1] && !is_mul_op(f);
    endfunction

endpackage

// File: rtl/exec_mul_unit.sv
// Multi-cycle mul/div unit: holds one operation and raises done for the
// cycle before its CDB edge.
module exec_mul_unit #(
    parameter int DATA_W  = 16,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 6
) (
    input  logic                             clk1,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             is_div,
    input  logic [DATA_W-1:0]                a,
    input  logic [DATA_W-1:0]                b,
    input  logic [tomasulo_pkg::RS_W-1:0]    rsindex,
    input  logic [tomasulo_pkg::ROB_W-1:0]   rob_ind,
    input  logic [tomasulo_pkg::REG_W-1:0]   rd,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_W-1:0]                result,
    output logic [tomasulo_pkg::RS_W-1:0]    res_rsindex,
    output logic [tomasulo_pkg::ROB_W-1:0]   res_rob_ind,
    output logic [tomasulo_pkg::REG_W-1:0]   res_rd
);
    import tomasulo_pkg::*;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    mu_state_e           state;
    logic [CNT_W-1:0]    cnt;
    logic                op_div;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2*DATA_W-1:0] prod;

    // Counter is loaded with LAT-1 so done is seen during the cycle that
    // ends on edge issue+LAT, where the top registers it onto the CDB.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state       <= MU_IDLE;
            cnt         <= '0;
            op_div      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_rsindex <= '0;
            res_rob_ind <= '0;
            res_rd      <= '0;
        end else if (start) begin
            state       <= MU_RUN;
            cnt         <= is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            op_div      <= is_div;
            a_q         <= a;
            b_q         <= b;
            res_rsindex <= rsindex;
            res_rob_ind <= rob_ind;
            res_rd      <= rd;
        end else if (state == MU_RUN) begin
            if (cnt == '0) begin
                state <= MU_IDLE;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy = (state == MU_RUN);
    assign done = (state == MU_RUN) && (cnt == '0);
    assign prod = (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);

    always_comb begin
        result = prod[DATA_W-1:0];
        if (op_div) begin
            result = (b_q == '0) ? '1 : a_q / b_q;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Tomasulo execute stage: single-cycle add unit, multi-cycle mul/div unit and
// one registered CDB where the mul unit wins collisions.
module exec_unit #(
    parameter int DATA_W  = tomasulo_pkg::DATA_W,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 6
) (
    input  logic                              clk1,
    input  logic                              rst,
    input  logic                              exec_b,
    input  logic [tomasulo_pkg::RS_W-1:0]     rsindex,
    input  logic [DATA_W-1:0]                 rs1data,
    input  logic [DATA_W-1:0]                 rs2data,
    input  logic [tomasulo_pkg::FUNC_W-1:0]   func,
    input  logic [tomasulo_pkg::ROB_W-1:0]    rob_ind,
    input  logic [tomasulo_pkg::REG_W-1:0]    rd,
    output logic                              add_busy,
    output logic                              mul_busy,
    output logic                              cdb_valid,
    output logic                              cdb_unit,
    output logic [tomasulo_pkg::RS_W-1:0]     cdb_rsindex,
    output logic [tomasulo_pkg::ROB_W-1:0]    cdb_rob_ind,
    output logic [tomasulo_pkg::REG_W-1:0]    cdb_rd,
    output logic [DATA_W-1:0]                 cdb_data
);
    import tomasulo_pkg::*;

    logic [FUNC_W-1:0] add_func;
    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic [RS_W-1:0]   add_rs;
    logic [ROB_W-1:0]  add_rob;
    logic [REG_W-1:0]  add_rd;
    logic [DATA_W-1:0] add_result;

    logic              mul_done;
    logic [DATA_W-1:0] mul_result;
    logic [RS_W-1:0]   mul_rs;
    logic [ROB_W-1:0]  mul_rob;
    logic [REG_W-1:0]  mul_rd;

    logic add_grant;
    logic add_accept;
    logic mul_accept;
    cdb_t cdb_q;

    // A unit may accept a new op on the same edge its result leaves.
    assign add_grant  = add_busy && !mul_done;
    assign add_accept = exec_b && is_add_op(func) && (!add_busy || add_grant);
    assign mul_accept = exec_b && is_mul_op(func) && (!mul_busy || mul_done);

    always_comb begin
        add_result = add_a + add_b;
        case (add_func)
            OP_SUB:  add_result = add_a - add_b;
            OP_BEQ:  add_result = DATA_W'(add_a == add_b);
            OP_BNE:  add_result = DATA_W'(add_a != add_b);
            default: add_result = add_a + add_b;
        endcase
    end

    exec_mul_unit #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mul (
        .clk1        (clk1),
        .rst         (rst),
        .start       (mul_accept),
        .is_div      (func == OP_DIV),
        .a           (rs1data),
        .b           (rs2data),
        .rsindex     (rsindex),
        .rob_ind     (rob_ind),
        .rd          (rd),
        .busy        (mul_busy),
        .done        (mul_done),
        .result      (mul_result),
        .res_rsindex (mul_rs),
        .res_rob_ind (mul_rob),
        .res_rd      (mul_rd)
    );

    // A blocked add keeps its holding register untouched, so the result
    // broadcast a cycle later is identical to the one that lost arbitration.
    always_ff @(posedge clk1) begin
        if (rst) begin
            cdb_q    <= '0;
            add_busy <= 1'b0;
            add_func <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_rs   <= '0;
            add_rob  <= '0;
            add_rd   <= '0;
        end else begin
            cdb_q <= '0;
            if (mul_done) begin
                cdb_q <= '{valid: 1'b1, unit: UNIT_MUL, rsindex: mul_rs,
                           rob_ind: mul_rob, rd: mul_rd, data: mul_result};
            end else if (add_busy) begin
                cdb_q <= '{valid: 1'b1, unit: UNIT_ADD, rsindex: add_rs,
                           rob_ind: add_rob, rd: add_rd, data: add_result};
            end

            if (add_accept) begin
                add_busy <= 1'b1;
                add_func <= func;
                add_a    <= rs1data;
                add_b    <= rs2data;
                add_rs   <= rsindex;
                add_rob  <= rob_ind;
                add_rd   <= rd;
            end else if (add_grant) begin
                add_busy <= 1'b0;
            end
        end
    end

    assign cdb_valid   = cdb_q.valid;
    assign cdb_unit    = cdb_q.unit;
    assign cdb_rsindex = cdb_q.rsindex;
    assign cdb_rob_ind = cdb_q.rob_ind;
    assign cdb_rd      = cdb_q.rd;
    assign cdb_data    = cdb_q.data;

endmodule

// File: tb/tb_exec_unit.sv
// Directed scoreboard bench for exec_unit: expected CDB beats are queued at
// issue with their broadcast cycle and checked as they appear.
module tb_exec_unit;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 6;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        exec_b;
    logic [1:0]  rsindex;
    logic [15:0] rs1data;
    logic [15:0] rs2data;
    logic [3:0]  func;
    logic [2:0]  rob_ind;
    logic [3:0]  rd;
    logic        add_busy;
    logic        mul_busy;
    logic        cdb_valid;
    logic        cdb_unit;
    logic [1:0]  cdb_rsindex;
    logic [2:0]  cdb_rob_ind;
    logic [3:0]  cdb_rd;
    logic [15:0] cdb_data;

    typedef struct {
        string       tag;
        int          cyc;
        logic        unit;
        logic [1:0]  rs;
        logic [2:0]  rob;
        logic [3:0]  rd;
        logic [15:0] data;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    exec_unit #(
        .DATA_W  (16),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .exec_b      (exec_b),
        .rsindex     (rsindex),
        .rs1data     (rs1data),
        .rs2data     (rs2data),
        .func        (func),
        .rob_ind     (rob_ind),
        .rd          (rd),
        .add_busy    (add_busy),
        .mul_busy    (mul_busy),
        .cdb_valid   (cdb_valid),
        .cdb_unit    (cdb_unit),
        .cdb_rsindex (cdb_rsindex),
        .cdb_rob_ind (cdb_rob_ind),
        .cdb_rd      (cdb_rd),
        .cdb_data    (cdb_data)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_cdb();
        exp_t e;
        if (cdb_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("cdb_unexpected", {31'd0, cdb_valid}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk({e.tag, "_cycle"}, cyc, e.cyc);
                chk({e.tag, "_bundle"},
                    {6'd0, cdb_unit, cdb_rsindex, cdb_rob_ind, cdb_rd, cdb_data},
                    {6'd0, e.unit, e.rs, e.rob, e.rd, e.data});
            end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            chk({e.tag, "_missing"}, {31'd0, cdb_valid}, 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
        cyc++;
        check_cdb();
    endtask

    task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] rs, input logic [2:0] rob, input logic [3:0] r);
        exec_b  = 1'b1;
        func    = f;
        rs1data = a;
        rs2data = b;
        rsindex = rs;
        rob_ind = rob;
        rd      = r;
    endtask

    task automatic idle();
        exec_b = 1'b0;
    endtask

    // lat counts edges after the issue edge; the issue edge is the next one.
    task automatic expect_cdb(input string tag, input int lat, input logic unit,
                              input logic [1:0] rs, input logic [2:0] rob,
                              input logic [3:0] r, input logic [15:0] data);
        sbq.push_back('{tag, cyc + 1 + lat, unit, rs, rob, r, data});
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sbq.size() > 0; i++) tick();
        chk("drain_pending", sbq.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        issue(4'b0000, '0, '0, '0, '0, '0);
        exec_b = 1'b0;
        tick();
        tick();
        chk("reset_state", {add_busy, mul_busy, cdb_valid, cdb_unit, cdb_rsindex,
                            cdb_rob_ind, cdb_rd, cdb_data}, '0);

        // Reset while a mul is in flight, with an add presented on the reset edge.
        rst = 1'b0;
        issue(4'b0010, 16'd300, 16'd300, 2'd0, 3'd1, 4'd1);
        tick();
        chk("mul_busy_set", mul_busy, 1);
        idle();
        tick();
        rst = 1'b1;
        issue(4'b0000, 16'd1, 16'd1, 2'd1, 3'd1, 4'd1);
        tick();
        chk("reset_inflight", {add_busy, mul_busy, cdb_valid, cdb_unit, cdb_rsindex,
                               cdb_rob_ind, cdb_rd, cdb_data}, '0);
        rst = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) tick();
        chk("reset_quiet_busy", {add_busy, mul_busy}, 0);

        // Single add.
        issue(4'b0000, 16'd5, 16'd7, 2'd1, 3'd2, 4'd3);
        expect_cdb("add_5_7", 1, 1'b0, 2'd1, 3'd2, 4'd3, 16'd12);
        tick();
        chk("add_busy_set", add_busy, 1);
        idle();
        tick();
        chk("add_busy_clear", add_busy, 0);

        // Back-to-back add-class ops, one result per cycle.
        issue(4'b0001, 16'd3, 16'd5, 2'd0, 3'd3, 4'd4);
        expect_cdb("sub_3_5", 1, 1'b0, 2'd0, 3'd3, 4'd4, 16'hFFFE);
        tick();
        issue(4'b0100, 16'h0010, 16'h0004, 2'd2, 3'd4, 4'd5);
        expect_cdb("load_addr", 1, 1'b0, 2'd2, 3'd4, 4'd5, 16'h0014);
        tick();
        issue(4'b0110, 16'd4, 16'd4, 2'd1, 3'd5, 4'd6);
        expect_cdb("beq_eq", 1, 1'b0, 2'd1, 3'd5, 4'd6, 16'd1);
        tick();
        issue(4'b0111, 16'd4, 16'd4, 2'd0, 3'd6, 4'd7);
        expect_cdb("bne_eq", 1, 1'b0, 2'd0, 3'd6, 4'd7, 16'd0);
        tick();
        issue(4'b0101, 16'hFFFF, 16'h0002, 2'd2, 3'd7, 4'd8);
        expect_cdb("store_wrap", 1, 1'b0, 2'd2, 3'd7, 4'd8, 16'h0001);
        tick();
        chk("add_busy_chain", add_busy, 1);
        idle();
        drain(4);

        // Mul/div latencies.
        issue(4'b0010, 16'd300, 16'd300, 2'd0, 3'd1, 4'd9);
        expect_cdb("mul_300_300", MUL_LAT, 1'b1, 2'd0, 3'd1, 4'd9, 16'h5F90);
        tick();
        idle();
        drain(10);
        issue(4'b0011, 16'd100, 16'd7, 2'd1, 3'd2, 4'd10);
        expect_cdb("div_100_7", DIV_LAT, 1'b1, 2'd1, 3'd2, 4'd10, 16'd14);
        tick();
        idle();
        drain(10);
        issue(4'b0011, 16'd9, 16'd0, 2'd2, 3'd3, 4'd11);
        expect_cdb("div_by_zero", DIV_LAT, 1'b1, 2'd2, 3'd3, 4'd11, 16'hFFFF);
        tick();
        idle();
        drain(10);

        // Collision: mul at N, add at N+2, extra add dropped while held.
        issue(4'b0010, 16'd6, 16'd7, 2'd0, 3'd4, 4'd12);
        expect_cdb("coll_mul", MUL_LAT, 1'b1, 2'd0, 3'd4, 4'd12, 16'd42);
        tick();
        idle();
        tick();
        issue(4'b0000, 16'd20, 16'd22, 2'd1, 3'd5, 4'd13);
        expect_cdb("coll_add", 2, 1'b0, 2'd1, 3'd5, 4'd13, 16'd42);
        tick();
        issue(4'b0000, 16'd1, 16'd2, 2'd2, 3'd6, 4'd14);
        tick();
        chk("coll_add_busy_held", add_busy, 1);
        chk("coll_mul_busy_clear", mul_busy, 0);
        idle();
        tick();
        chk("coll_add_busy_clear", add_busy, 0);
        for (int i = 0; i < 4; i++) tick();

        // Mul issued while mul busy is dropped.
        issue(4'b0010, 16'd2, 16'd3, 2'd1, 3'd0, 4'd15);
        expect_cdb("mul_2_3", MUL_LAT, 1'b1, 2'd1, 3'd0, 4'd15, 16'd6);
        tick();
        issue(4'b0011, 16'd8, 16'd2, 2'd2, 3'd7, 4'd1);
        tick();
        idle();
        drain(10);
        for (int i = 0; i < 8; i++) tick();

        // Reserved opcode does nothing.
        issue(4'b1010, 16'd1, 16'd1, 2'd1, 3'd1, 4'd1);
        tick();
        chk("reserved_op_busy", {add_busy, mul_busy}, 0);
        idle();
        for (int i = 0; i < 8; i++) tick();
        chk("final_queue", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
